// File: rtl/motor_drv_if.sv
// Bridge-side bundle of motor_drv: direction command in, bridge pins, PWM enables and dead-time flag out.
// The controller/bench drives through master; the driver stage sits on slave.
interface motor_drv_if;
    logic [3:0] motor;
    logic [3:0] br_in;
    logic       ena;
    logic       enb;
    logic       busy;

    modport master (output motor, input br_in, ena, enb, busy);
    modport slave  (input motor, output br_in, ena, enb, busy);
endinterface

// File: rtl/motor_drv.sv
// Dual H-bridge driver: per-wheel direction FSM, ramped shared-counter PWM, dead-time on polarity change.
// Latency: motor -> br_in 3 edges, -> ena/enb 4 edges; no backpressure, command is level-sampled every cycle.
module motor_drv #(
    parameter int PWM_DIV   = 1000,
    parameter int DUTY_MAX  = 800,
    parameter int RAMP_STEP = 20,
    parameter int RAMP_DIV  = 50000,
    parameter int DEAD_CYC  = 5000
) (
    input  logic        clk,
    input  logic        rst_n,
    motor_drv_if.slave  bus
);
    localparam int DUTY_W = $clog2(PWM_DIV + 1);
    localparam int RAMP_W = $clog2(RAMP_DIV + 1);
    localparam int DEAD_W = $clog2(DEAD_CYC + 1);

    localparam logic [DUTY_W-1:0] PWM_LAST  = DUTY_W'(PWM_DIV - 1);
    localparam logic [DUTY_W-1:0] DUTY_CEIL = DUTY_W'(DUTY_MAX);
    localparam logic [DUTY_W:0]   STEP_EXT  = (DUTY_W + 1)'(RAMP_STEP);
    localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_DIV - 1);
    localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_CYC - 1);

    localparam logic [1:0] CMD_COAST = 2'b00;
    localparam logic [1:0] CMD_BRAKE = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DEAD, S_BRAKE} state_t;

    logic [3:0]        r_sync1;
    logic [3:0]        r_sync2;
    logic [DUTY_W-1:0] r_pwm_cnt;
    logic [RAMP_W-1:0] r_ramp_cnt;
    logic              w_tick;
    logic [1:0]        w_pins [2];
    logic              w_en   [2];
    logic              w_dead [2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1    <= 4'b0000;
            r_sync2    <= 4'b0000;
            r_pwm_cnt  <= '0;
            r_ramp_cnt <= '0;
        end else begin
            r_sync1    <= bus.motor;
            r_sync2    <= r_sync1;
            r_pwm_cnt  <= (r_pwm_cnt == PWM_LAST) ? '0 : r_pwm_cnt + 1'b1;
            r_ramp_cnt <= (r_ramp_cnt == RAMP_LAST) ? '0 : r_ramp_cnt + 1'b1;
        end
    end

    assign w_tick = (r_ramp_cnt == RAMP_LAST);

    for (genvar w = 0; w < 2; w++) begin : g_wheel
        state_t            r_state;
        logic [1:0]        r_dir;
        logic [DUTY_W-1:0] r_duty;
        logic [DEAD_W-1:0] r_dead_cnt;
        logic [1:0]        r_pins;
        logic              r_en;
        logic              r_dead;
        logic [1:0]        w_cmd;
        logic              w_fwd_rev;
        logic [DUTY_W:0]   w_duty_sum;
        logic [DUTY_W-1:0] w_duty_inc;

        assign w_cmd      = r_sync2[2*w +: 2];
        assign w_fwd_rev  = (w_cmd == 2'b10) || (w_cmd == 2'b01);
        // Sum is one bit wider so saturation is detected before any wrap.
        assign w_duty_sum = {1'b0, r_duty} + STEP_EXT;
        assign w_duty_inc = (w_duty_sum > {1'b0, DUTY_CEIL}) ? DUTY_CEIL : w_duty_sum[DUTY_W-1:0];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state    <= S_IDLE;
                r_dir      <= 2'b00;
                r_duty     <= '0;
                r_dead_cnt <= '0;
                r_pins     <= 2'b00;
                r_en       <= 1'b0;
                r_dead     <= 1'b0;
            end else begin
                r_en <= (r_state == S_BRAKE) || ((r_state == S_RUN) && (r_pwm_cnt < r_duty));
                case (r_state)
                    S_IDLE: begin
                        r_duty <= '0;
                        if (w_fwd_rev) begin
                            r_state <= S_RUN;
                            r_dir   <= w_cmd;
                            r_pins  <= w_cmd;
                        end else if (w_cmd == CMD_BRAKE) begin
                            r_state <= S_BRAKE;
                            r_pins  <= 2'b11;
                        end
                    end
                    S_RUN: begin
                        if (w_cmd == r_dir) begin
                            if (w_tick) r_duty <= w_duty_inc;
                        end else begin
                            r_duty <= '0;
                            if (w_cmd == CMD_COAST) begin
                                r_state <= S_IDLE;
                                r_pins  <= 2'b00;
                            end else if (w_cmd == CMD_BRAKE) begin
                                r_state <= S_BRAKE;
                                r_pins  <= 2'b11;
                            end else begin
                                r_state    <= S_DEAD;
                                r_pins     <= 2'b00;
                                r_dead_cnt <= '0;
                                r_dead     <= 1'b1;
                            end
                        end
                    end
                    S_DEAD: begin
                        // Exit decision uses whatever cmd is present at the end; earlier changes are ignored.
                        if (r_dead_cnt == DEAD_LAST) begin
                            r_dead <= 1'b0;
                            r_duty <= '0;
                            if (w_fwd_rev) begin
                                r_state <= S_RUN;
                                r_dir   <= w_cmd;
                                r_pins  <= w_cmd;
                            end else if (w_cmd == CMD_BRAKE) begin
                                r_state <= S_BRAKE;
                                r_pins  <= 2'b11;
                            end else begin
                                r_state <= S_IDLE;
                                r_pins  <= 2'b00;
                            end
                        end else begin
                            r_dead_cnt <= r_dead_cnt + 1'b1;
                        end
                    end
                    S_BRAKE: begin
                        r_duty <= '0;
                        if (w_cmd == CMD_COAST) begin
                            r_state <= S_IDLE;
                            r_pins  <= 2'b00;
                        end else if (w_fwd_rev) begin
                            r_state    <= S_DEAD;
                            r_pins     <= 2'b00;
                            r_dead_cnt <= '0;
                            r_dead     <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_pins  <= 2'b00;
                        r_duty  <= '0;
                        r_dead  <= 1'b0;
                    end
                endcase
            end
        end

        assign w_pins[w] = r_pins;
        assign w_en[w]   = r_en;
        assign w_dead[w] = r_dead;
    end

    assign bus.br_in = {w_pins[1], w_pins[0]};
    assign bus.ena   = w_en[0];
    assign bus.enb   = w_en[1];
    assign bus.busy  = w_dead[0] | w_dead[1];
endmodule
